// File: rtl/mul_issue_sched_pkg.sv
// Shared types for the multiply issue scheduler: register index, scoreboard entry,
// and the source-vs-destination match used by the hazard check.
package mul_issue_sched_pkg;

  localparam int MUL_DEPTH_DEF = 4;
  localparam int REG_W         = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t dest;
  } sb_entry_t;

  // r0 is hardwired zero, so an in-flight write to it never creates a dependency
  function automatic logic src_match(reg_idx_t rs, reg_idx_t rt, sb_entry_t e);
    return e.valid && (e.dest != '0) && ((rs == e.dest) || (rt == e.dest));
  endfunction

endpackage

// File: rtl/mul_issue_sched_arb.sv
// Two-input round-robin arbiter: one-hot grant, pointer remembers the last winner
// and only moves when something is granted.
module mul_rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] elig,
  output logic [1:0] grant
);

  logic last_b;

  // Reset points at B so that A wins the first tie
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       last_b <= 1'b1;
    else if (|grant)  last_b <= grant[1];
  end

  always_comb begin
    grant = 2'b00;
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_b ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mul_issue_sched.sv
// Multiply issue scheduler: round-robin between slots A/B, registered multiplier
// entry stage, destination scoreboard. Hazard check enabled by MUL_ISSUE_SCHED_HAZARD_EN.
module mul_issue_sched
  import mul_issue_sched_pkg::*;
#(
  parameter int MUL_DEPTH = MUL_DEPTH_DEF,
  parameter int CNT_W     = $clog2(MUL_DEPTH+2)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_a_valid,
  output logic             req_a_ready,
  input  logic [4:0]       req_a_rs,
  input  logic [4:0]       req_a_rt,
  input  logic [4:0]       req_a_rd,
  input  logic [31:0]      req_a_opa,
  input  logic [31:0]      req_a_opb,
  input  logic             req_b_valid,
  output logic             req_b_ready,
  input  logic [4:0]       req_b_rs,
  input  logic [4:0]       req_b_rt,
  input  logic [4:0]       req_b_rd,
  input  logic [31:0]      req_b_opa,
  input  logic [31:0]      req_b_opb,
  input  logic             flush,
  output logic             mul_m0_oper,
  output logic [31:0]      mul_m0_rega,
  output logic [31:0]      mul_m0_regb,
  output logic [4:0]       mul_m0_regdest,
  output logic             done_valid,
  output logic [4:0]       done_dest,
  output logic [CNT_W-1:0] inflight
);

`ifdef MUL_ISSUE_SCHED_HAZARD_EN
  localparam bit HAZ_EN = 1'b1;
`else
  localparam bit HAZ_EN = 1'b0;
`endif

  sb_entry_t        sb     [0:MUL_DEPTH];
  sb_entry_t        sb_nxt [0:MUL_DEPTH];
  logic             haz_a, haz_b;
  logic [1:0]       elig, grant;
  reg_idx_t         win_rd;
  logic [31:0]      win_opa, win_opb;
  logic [31:0]      rega, regb;
  logic [CNT_W-1:0] cnt_nxt;

  // The last entry is checked too: its result is only visible to writeback this cycle
  always_comb begin
    haz_a = 1'b0;
    haz_b = 1'b0;
    for (int i = 0; i <= MUL_DEPTH; i++) begin
      haz_a = haz_a | src_match(req_a_rs, req_a_rt, sb[i]);
      haz_b = haz_b | src_match(req_b_rs, req_b_rt, sb[i]);
    end
  end

  // Holding eligibility low in reset keeps ready at zero while the flops are cleared
  assign elig[0] = reset & req_a_valid & ~flush & ~(HAZ_EN & haz_a);
  assign elig[1] = reset & req_b_valid & ~flush & ~(HAZ_EN & haz_b);

  mul_rr_arb2 u_arb (
    .clock (clock),
    .reset (reset),
    .elig  (elig),
    .grant (grant)
  );

  assign req_a_ready = grant[0];
  assign req_b_ready = grant[1];

  assign win_rd  = grant[1] ? req_b_rd  : req_a_rd;
  assign win_opa = grant[1] ? req_b_opa : req_a_opa;
  assign win_opb = grant[1] ? req_b_opb : req_a_opb;

  always_comb begin
    sb_nxt[0] = (|grant) ? '{valid: 1'b1, dest: win_rd} : '0;
    for (int i = 1; i <= MUL_DEPTH; i++) sb_nxt[i] = sb[i-1];
    if (flush)
      for (int i = 0; i <= MUL_DEPTH; i++) sb_nxt[i] = '0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i <= MUL_DEPTH; i++) cnt_nxt = cnt_nxt + CNT_W'(sb_nxt[i].valid);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i <= MUL_DEPTH; i++) sb[i] <= '0;
      rega     <= '0;
      regb     <= '0;
      inflight <= '0;
    end else begin
      for (int i = 0; i <= MUL_DEPTH; i++) sb[i] <= sb_nxt[i];
      rega     <= (|grant) ? win_opa : '0;
      regb     <= (|grant) ? win_opb : '0;
      inflight <= cnt_nxt;
    end
  end

  // sb[0] doubles as the valid/dest half of the entry-stage register
  assign mul_m0_oper    = sb[0].valid;
  assign mul_m0_regdest = sb[0].dest;
  assign mul_m0_rega    = rega;
  assign mul_m0_regb    = regb;
  assign done_valid     = sb[MUL_DEPTH].valid;
  assign done_dest      = sb[MUL_DEPTH].dest;

endmodule

// File: tb/tb_mul_issue_sched.sv
// Table-driven bench for mul_issue_sched (MUL_DEPTH=4): each row is one cycle of
// stimulus plus the readies and registered outputs expected during that cycle.
module tb_mul_issue_sched;

`ifdef MUL_ISSUE_SCHED_HAZARD_EN
  localparam int HZ = 1;
`else
  localparam int HZ = 0;
`endif
  localparam int NB = (HZ != 0) ? 0 : 1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_a_valid = 1'b0, req_b_valid = 1'b0, flush = 1'b0;
  logic        req_a_ready, req_b_ready;
  logic [4:0]  req_a_rs = '0, req_a_rt = '0, req_a_rd = '0;
  logic [4:0]  req_b_rs = '0, req_b_rt = '0, req_b_rd = '0;
  logic [31:0] req_a_opa = '0, req_a_opb = '0, req_b_opa = '0, req_b_opb = '0;
  logic        mul_m0_oper, done_valid;
  logic [31:0] mul_m0_rega, mul_m0_regb;
  logic [4:0]  mul_m0_regdest, done_dest;
  logic [2:0]  inflight;

  int checks = 0;
  int errors = 0;

  mul_issue_sched dut (
    .clock(clock), .reset(reset),
    .req_a_valid(req_a_valid), .req_a_ready(req_a_ready), .req_a_rs(req_a_rs),
    .req_a_rt(req_a_rt), .req_a_rd(req_a_rd), .req_a_opa(req_a_opa), .req_a_opb(req_a_opb),
    .req_b_valid(req_b_valid), .req_b_ready(req_b_ready), .req_b_rs(req_b_rs),
    .req_b_rt(req_b_rt), .req_b_rd(req_b_rd), .req_b_opa(req_b_opa), .req_b_opb(req_b_opb),
    .flush(flush), .mul_m0_oper(mul_m0_oper), .mul_m0_rega(mul_m0_rega),
    .mul_m0_regb(mul_m0_regb), .mul_m0_regdest(mul_m0_regdest),
    .done_valid(done_valid), .done_dest(done_dest), .inflight(inflight)
  );

  always #5 clock = ~clock;

  typedef struct {
    int pre, chk;
    int av, ars, art, ard;
    int bv, brs, brt, brd;
    int fl;
    int ra, rb, oper, dest, dv, dd, inf;
  } vec_t;

  vec_t vq[$];

  // Operands are derived from rd so each op's data is distinct and predictable
  function automatic logic [31:0] opa_of(int rd); return 32'(rd * 7 + 100); endfunction
  function automatic logic [31:0] opb_of(int rd); return 32'(rd * 13 + 200); endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_a_valid = v.av[0]; req_a_rs = 5'(v.ars); req_a_rt = 5'(v.art); req_a_rd = 5'(v.ard);
    req_a_opa = opa_of(v.ard); req_a_opb = opb_of(v.ard);
    req_b_valid = v.bv[0]; req_b_rs = 5'(v.brs); req_b_rt = 5'(v.brt); req_b_rd = 5'(v.brd);
    req_b_opa = opa_of(v.brd); req_b_opb = opb_of(v.brd);
    flush = v.fl[0];
  endtask

  task automatic do_reset();
    vec_t idle;
    idle = '{default: 0};
    drive(idle);
    reset = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic add_idle(input int n, input int dv, input int dd, input int inf);
    for (int k = 0; k < n; k++)
      vq.push_back('{0,1, 0,0,0,0, 0,0,0,0, 0, 0,0, 0,0,dv,dd,inf});
  endtask

  initial begin
    // single op
    vq.push_back('{1,1, 1,1,2,3, 0,0,0,0, 0, 1,0, 0,0,0,0,0});
    vq.push_back('{0,1, 0,0,0,0, 0,0,0,0, 0, 0,0, 1,3,0,0,1});
    add_idle(3, 0, 0, 1);
    add_idle(1, 1, 3, 1);
    add_idle(1, 0, 0, 0);
    // tie between independent requesters alternates, A first after reset
    vq.push_back('{1,1, 1,1,2,10, 1,4,6,11, 0, 1,0, 0,0,0,0,0});
    vq.push_back('{0,1, 1,1,2,10, 1,4,6,11, 0, 0,1, 1,10,0,0,1});
    vq.push_back('{0,1, 1,1,2,10, 1,4,6,11, 0, 1,0, 1,11,0,0,2});
    vq.push_back('{0,1, 1,1,2,10, 1,4,6,11, 0, 0,1, 1,10,0,0,3});
    vq.push_back('{0,1, 0,0,0,0, 0,0,0,0, 0, 0,0, 1,11,0,0,4});
    add_idle(1, 1, 10, 4);
    add_idle(1, 1, 11, 3);
    // RAW on rs: blocked while rd=5 is anywhere in the scoreboard
    vq.push_back('{1,1, 1,1,2,5, 1,5,7,8, 0, 1,0, 0,0,0,0,0});
    vq.push_back('{0,1, 0,0,0,0, 1,5,7,8, 0, 0,NB, 1,5,0,0,1});
    for (int k = 0; k < 4; k++)
      vq.push_back('{0,0, 0,0,0,0, 1,5,7,8, 0, 0,NB, 0,0,0,0,0});
    vq.push_back('{0,0, 0,0,0,0, 1,5,7,8, 0, 0,1, 0,0,0,0,0});
    // RAW on rt
    vq.push_back('{1,1, 1,1,2,6, 0,0,0,0, 0, 1,0, 0,0,0,0,0});
    vq.push_back('{0,1, 0,0,0,0, 1,9,6,8, 0, 0,NB, 1,6,0,0,1});
    // rd=0 never blocks
    vq.push_back('{1,1, 1,1,2,0, 0,0,0,0, 0, 1,0, 0,0,0,0,0});
    vq.push_back('{0,1, 0,0,0,0, 1,0,0,9, 0, 0,1, 1,0,0,0,1});
    add_idle(1, 0, 0, 2);
    vq[$].oper = 1; vq[$].dest = 9;
    // flush with two ops in flight: no completions afterwards
    vq.push_back('{1,1, 1,1,2,12, 0,0,0,0, 0, 1,0, 0,0,0,0,0});
    vq.push_back('{0,1, 0,0,0,0, 1,3,4,13, 0, 0,1, 1,12,0,0,1});
    vq.push_back('{0,1, 1,1,2,14, 1,3,4,15, 1, 0,0, 1,13,0,0,2});
    add_idle(6, 0, 0, 0);
    // flush in the completion cycle still shows that completion
    vq.push_back('{1,1, 1,1,2,17, 0,0,0,0, 0, 1,0, 0,0,0,0,0});
    vq.push_back('{0,1, 0,0,0,0, 0,0,0,0, 0, 0,0, 1,17,0,0,1});
    add_idle(3, 0, 0, 1);
    vq.push_back('{0,1, 1,1,2,18, 0,0,0,0, 1, 0,0, 0,0,1,17,1});
    add_idle(2, 0, 0, 0);

    // reset state
    #1;
    chk("rst_oper", 32'(mul_m0_oper), 0);
    chk("rst_rega", mul_m0_rega, 0);
    chk("rst_dest", 32'(mul_m0_regdest), 0);
    chk("rst_done", 32'(done_valid), 0);
    chk("rst_inflight", 32'(inflight), 0);

    do_reset();
    foreach (vq[i]) begin
      if (vq[i].pre != 0) do_reset();
      drive(vq[i]);
      @(negedge clock);
      chk($sformatf("row%0d_ready_a", i), 32'(req_a_ready), 32'(vq[i].ra));
      chk($sformatf("row%0d_ready_b", i), 32'(req_b_ready), 32'(vq[i].rb));
      if (vq[i].chk != 0) begin
        chk($sformatf("row%0d_oper", i), 32'(mul_m0_oper), 32'(vq[i].oper));
        chk($sformatf("row%0d_regdest", i), 32'(mul_m0_regdest), 32'(vq[i].dest));
        chk($sformatf("row%0d_rega", i), mul_m0_rega, (vq[i].oper != 0) ? opa_of(vq[i].dest) : 32'd0);
        chk($sformatf("row%0d_regb", i), mul_m0_regb, (vq[i].oper != 0) ? opb_of(vq[i].dest) : 32'd0);
        chk($sformatf("row%0d_done_valid", i), 32'(done_valid), 32'(vq[i].dv));
        chk($sformatf("row%0d_done_dest", i), 32'(done_dest), 32'(vq[i].dd));
        chk($sformatf("row%0d_inflight", i), 32'(inflight), 32'(vq[i].inf));
      end
      @(posedge clock);
      #1;
    end

    // async reset mid-cycle clears outputs at once and returns the pointer to B
    do_reset();
    drive('{0,0, 1,1,2,20, 0,0,0,0, 0, 0,0,0,0,0,0,0});
    #1 chk("ar_first_a", 32'(req_a_ready), 1);
    @(posedge clock);
    #1 drive('{0,0, 1,1,2,20, 1,3,4,21, 0, 0,0,0,0,0,0,0});
    #1;
    chk("ar_pre_oper", 32'(mul_m0_oper), 1);
    chk("ar_pre_ready_b", 32'(req_b_ready), 1);
    reset = 1'b0;
    #1;
    chk("ar_oper", 32'(mul_m0_oper), 0);
    chk("ar_rega", mul_m0_rega, 0);
    chk("ar_regdest", 32'(mul_m0_regdest), 0);
    chk("ar_inflight", 32'(inflight), 0);
    chk("ar_ready_a", 32'(req_a_ready), 0);
    chk("ar_ready_b", 32'(req_b_ready), 0);
    reset = 1'b1;
    #1;
    chk("ar_ptr_ready_a", 32'(req_a_ready), 1);
    chk("ar_ptr_ready_b", 32'(req_b_ready), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_issue_sched.md
# mul_issue_sched

Issue scheduler for the pipelined integer multiplier. It arbitrates round-robin between two multiply requesters (issue slots A and B) and drives the multiplier's first-stage inputs from a registered output. A destination scoreboard blocks any request whose source registers depend on a multiply still in flight. It sits between the issue stage and the multiplier's entry stage, and reports completions to writeback.

## Interface
Parameters:
- MUL_DEPTH, default 4: cycles from capture into the multiplier entry stage to result availability; must be ≥ 1.
- CNT_W, default $clog2(MUL_DEPTH+2): width of the in-flight counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low.
- req_a_valid  in  1  requester A has a multiply.
- req_a_ready  out  1  requester A accepted this cycle (combinational).
- req_a_rs, req_a_rt  in  5 each  source register indices.
- req_a_rd  in  5  destination register index.
- req_a_opa, req_a_opb  in  32 each  operand values.
- req_b_valid, req_b_ready, req_b_rs, req_b_rt, req_b_rd, req_b_opa, req_b_opb  same directions/widths/meaning, requester B.
- flush  in  1  kill all in-flight multiplies.
- mul_m0_oper  out  1  operation valid into multiplier entry stage.
- mul_m0_rega, mul_m0_regb  out  32 each  operands.
- mul_m0_regdest  out  5  destination index.
- done_valid  out  1  a multiply's result is available this cycle.
- done_dest  out  5  destination of completing multiply.
- inflight  out  CNT_W  count of valid scoreboard entries.

## Operation
- Scoreboard: MUL_DEPTH+1 entries sb[0..MUL_DEPTH], each {valid, dest}.
  - sb[0] mirrors the issue register; it loads on grant, otherwise valid=0.
  - Every cycle sb[i+1] <= sb[i].
  - done_valid/done_dest = sb[MUL_DEPTH].
- Eligibility of requester X: valid, no flush, and no hazard.
- Hazard: rs or rt equals dest of any valid sb entry, including sb[MUL_DEPTH]. Index 0 never hazards. Entries with dest 0 still advance but never match.
- Arbitration:
  - Only A eligible → grant A; only B eligible → grant B.
  - Both eligible → grant the one not granted last. The last-grant pointer updates only on a grant; its reset value is B, so A wins the first tie.
  - At most one grant per cycle; ready is high only for the granted requester.
- On grant: mul_m0_oper<=1, mul_m0_rega/regb/regdest <= winner's opa/opb/rd, sb[0]<={1,rd}.
- No grant: mul_m0_oper<=0 and rega/regb/regdest<=0, matching the multiplier's convention of zeroed data on idle.
- Flush:
  - Both readys are forced low that cycle.
  - Next edge: all sb valid cleared, mul_m0_* zeroed.
  - done_valid in the flush cycle still reflects the current sb[MUL_DEPTH].
- Back-to-back dependent requests from A then B: the second is blocked by sb[0] match. No forwarding.
- Reset values: all outputs 0, all sb valid 0, pointer = B.
- inflight: popcount of sb valids, registered alongside sb.

## Timing
- Request → mul_m0_oper: 1 cycle (registered).
- Grant in cycle t → done_valid in cycle t+1+MUL_DEPTH.
- A dependent request on rd is first grantable in cycle t+MUL_DEPTH+2.
- Ready is combinational from valid, indices and current sb. Requesters hold inputs until ready.
- Reset asserted mid-operation clears everything asynchronously. No completion is reported for ops killed by reset or flush.

## Configuration
- MUL_ISSUE_SCHED_HAZARD_EN defined: scoreboard hazard check active, as above.
- Undefined:
  - The hazard term is constant 0, so eligibility = valid and no flush. Software guarantees spacing.
  - The scoreboard is still kept for done_valid/done_dest/inflight.

## Structure
- Shared package: MUL_DEPTH default, the 5-bit register-index typedef, and the scoreboard entry typedef {valid, dest}.
- One sub-module, mul_rr_arb2: a two-input round-robin arbiter with pointer register, taking eligibility bits and returning one-hot grant.

## Test plan
- Single op: A valid, opa=7, opb=6, rd=3 → cycle 1 mul_m0_oper=1, rega=7, regb=6, regdest=3; cycle 5 done_valid=1, done_dest=3; inflight returns to 0.
- Tie: A and B both valid, independent, held → grants alternate A,B,A,B. After reset the first grant is A.
- RAW hazard: A rd=5 granted, then B rs=5 → B ready low for cycles 1..5, granted in cycle 6. With macro undefined, granted in cycle 1.
- Zero register: A rd=0 granted, B rs=0 next cycle → B granted immediately.
- Flush: two ops in flight, flush pulsed → readys low that cycle; next cycle inflight=0, mul_m0_oper=0, no later done_valid.
- Async reset mid-stream: reset low between edges → all outputs 0 immediately; pointer returns to B.
